// File: rtl/logic_arb_pkg.sv
// Shared types for the logic unit arbiter: opcode and FSM state encodings.
package logic_arb_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'd0,
    OP_OR  = 2'd1,
    OP_XOR = 2'd2,
    OP_NOT = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/logic_unit_arbiter_bitwise.sv
// Combinational N-bit bitwise unit (AND/OR/XOR/NOT A), one slice per bit.
// LOGIC_UNIT_ARB_XOR_EN: when undefined, opcode 2 aliases to OR and no XOR gates exist.
module bitwise_unit
  import logic_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  op_t          op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] y
);

  for (genvar i = 0; i < N; i++) begin : g_bit
    logic yb;
    always_comb begin
      yb = 1'b0;
      case (op)
        OP_AND: yb = a[i] & b[i];
        OP_OR:  yb = a[i] | b[i];
`ifdef LOGIC_UNIT_ARB_XOR_EN
        OP_XOR: yb = a[i] ^ b[i];
`else
        OP_XOR: yb = a[i] | b[i];
`endif
        OP_NOT: yb = ~a[i];
        default: yb = 1'b0;
      endcase
    end
    assign y[i] = yb;
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise unit among REQ requesters.
// Build option LOGIC_UNIT_ARB_XOR_EN enables a real XOR for opcode 2.
module logic_unit_arbiter
  import logic_arb_pkg::*;
#(
  parameter  int N   = 4,
  parameter  int REQ = 4,
  localparam int IDW = $clog2(REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REQ-1:0]     req_valid,
  output logic [REQ-1:0]     req_ready,
  input  logic [2*REQ-1:0]   req_op,
  input  logic [N*REQ-1:0]   req_a,
  input  logic [N*REQ-1:0]   req_b,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [N-1:0]       res_data,
  output logic [IDW-1:0]     res_id,
  output logic               busy
);

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr, win, ptr_nxt, id_q;
  logic [IDW:0]   sum;
  logic           found, hs;
  op_t            op_q;
  logic [N-1:0]   a_q, b_q, y;

  // First valid requester at or above ptr, wrapping at REQ-1 -> 0.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    for (int k = 0; k < REQ; k++) begin
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(REQ)) sum = sum - (IDW+1)'(REQ);
      if (!found && req_valid[sum[IDW-1:0]]) begin
        found = 1'b1;
        win   = sum[IDW-1:0];
      end
    end
  end

  assign hs        = found && (state == S_IDLE) && !rst;
  assign req_ready = hs ? (REQ'(1) << win) : '0;
  assign ptr_nxt   = (win == IDW'(REQ-1)) ? '0 : win + 1'b1;
  assign res_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (hs) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_DONE;
      S_DONE:  if (res_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ptr      <= '0;
      op_q     <= OP_AND;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= '0;
      res_data <= '0;
      res_id   <= '0;
    end else begin
      state <= state_nxt;
      if (hs) begin
        op_q <= op_t'(req_op[2*win +: 2]);
        a_q  <= req_a[N*win +: N];
        b_q  <= req_b[N*win +: N];
        id_q <= win;
        ptr  <= ptr_nxt;
      end
      // Result is captured once in EXEC and then held through DONE.
      if (state == S_EXEC) begin
        res_data <= y;
        res_id   <= id_q;
      end
    end
  end

  bitwise_unit #(.N(N)) u_bitwise (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .y  (y)
  );

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter with a round-robin/result reference model.
module tb_logic_unit_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req_valid = '0;
  logic [3:0] req_ready;
  logic [7:0] req_op;
  logic [15:0] req_a, req_b;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [3:0] res_data;
  logic [1:0] res_id;
  logic       busy;

  logic [1:0] l_op [4];
  logic [3:0] l_a  [4];
  logic [3:0] l_b  [4];

  int pass = 0;
  int total = 0;
  int m_ptr = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_op = '0; req_a = '0; req_b = '0;
    for (int i = 0; i < 4; i++) begin
      req_op[2*i +: 2] = l_op[i];
      req_a[4*i +: 4]  = l_a[i];
      req_b[4*i +: 4]  = l_b[i];
    end
  end

  logic_unit_arbiter #(.N(4), .REQ(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_id(res_id), .busy(busy)
  );

  function automatic int win_of(input logic [3:0] mask);
    for (int k = 0; k < 4; k++)
      if (mask[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] ref_op(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      2'd0: return a & b;
      2'd1: return a | b;
`ifdef LOGIC_UNIT_ARB_XOR_EN
      2'd2: return a ^ b;
`else
      2'd2: return a | b;
`endif
      default: return ~a;
    endcase
  endfunction

  task automatic rand_lanes();
    for (int i = 0; i < 4; i++) begin
      l_op[i] = 2'($urandom);
      l_a[i]  = 4'($urandom);
      l_b[i]  = 4'($urandom);
    end
  endtask

  task automatic test_reset();
    int w;
    logic [3:0] exp;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      rand_lanes(); req_valid = 4'($urandom); res_ready = 1'($urandom);
      #1;
      total++; if (req_ready !== 4'b0) $display("FAIL reset_ready: got %b want 0000", req_ready); else pass++;
      total++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid: got %b want 0", res_valid); else pass++;
      total++; if (res_data !== 4'b0) $display("FAIL reset_res_data: got %b want 0000", res_data); else pass++;
      total++; if (res_id !== 2'b0) $display("FAIL reset_res_id: got %0d want 0", res_id); else pass++;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass++;
    end
    m_ptr = 0;
    @(negedge clk);
    rst = 1'b0; req_valid = 4'b0100; res_ready = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0100) $display("FAIL reset_first_grant: got %b want 0100", req_ready); else pass++;
    w = win_of(req_valid); m_ptr = (w + 1) % 4;
    exp = ref_op(l_op[2], l_a[2], l_b[2]);
    @(negedge clk); req_valid = '0; #1;
    total++; if (busy !== 1'b1 || res_valid !== 1'b0) $display("FAIL reset_exec: busy %b res_valid %b want 1 0", busy, res_valid); else pass++;
    @(negedge clk); #1;
    total++; if (res_valid !== 1'b1 || res_data !== exp || res_id !== 2'd2)
      $display("FAIL reset_result: valid %b data %b id %0d want 1 %b 2", res_valid, res_data, res_id, exp); else pass++;
    @(negedge clk); #1;
    total++; if (busy !== 1'b0) $display("FAIL reset_back_idle: busy %b want 0", busy); else pass++;
  endtask

  task automatic test_single_or();
    int w;
    @(negedge clk);
    l_op[0] = 2'd1; l_a[0] = 4'b1010; l_b[0] = 4'b0101; req_valid = 4'b0001; res_ready = 1'b1;
    #1;
    w = win_of(req_valid);
    total++; if (req_ready !== (4'b0001 << w)) $display("FAIL or_grant: got %b want %b", req_ready, 4'b0001 << w); else pass++;
    m_ptr = (w + 1) % 4;
    @(negedge clk); req_valid = '0; #1;
    total++; if (busy !== 1'b1 || res_valid !== 1'b0) $display("FAIL or_exec: busy %b res_valid %b want 1 0", busy, res_valid); else pass++;
    @(negedge clk); #1;
    total++; if (res_valid !== 1'b1 || res_data !== 4'b1111 || res_id !== 2'd0 || busy !== 1'b1)
      $display("FAIL or_result: valid %b data %b id %0d busy %b want 1 1111 0 1", res_valid, res_data, res_id, busy); else pass++;
    @(negedge clk); #1;
    total++; if (busy !== 1'b0 || res_valid !== 1'b0) $display("FAIL or_idle: busy %b res_valid %b want 0 0", busy, res_valid); else pass++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    @(negedge clk); rst = 1'b1; req_valid = '0;
    @(negedge clk); rst = 1'b0; m_ptr = 0;
    rand_lanes();
    for (int i = 0; i < 4; i++) l_op[i] = 2'd0;
    req_valid = 4'hf; res_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      #1;
      total++; if (req_ready !== (4'b0001 << (g % 4))) $display("FAIL rr_grant%0d: got %b want %b", g, req_ready, 4'b0001 << (g % 4)); else pass++;
      exp = l_a[g % 4] & l_b[g % 4];
      m_ptr = (g % 4 + 1) % 4;
      @(negedge clk); #1;
      total++; if (req_ready !== 4'b0) $display("FAIL rr_exec_ready%0d: got %b want 0000", g, req_ready); else pass++;
      @(negedge clk); #1;
      total++; if (res_valid !== 1'b1 || res_data !== exp || res_id !== 2'(g % 4))
        $display("FAIL rr_result%0d: valid %b data %b id %0d want 1 %b %0d", g, res_valid, res_data, res_id, exp, g % 4); else pass++;
      @(negedge clk);
      if (g == 4) req_valid = '0;
    end
  endtask

  task automatic test_backpressure();
    int idx, w;
    logic [3:0] exp;
    idx = $urandom_range(0, 3);
    rand_lanes();
    @(negedge clk); req_valid = 4'b0001 << idx; res_ready = 1'b0; #1;
    w = win_of(req_valid);
    total++; if (req_ready !== (4'b0001 << w)) $display("FAIL bp_grant: got %b want %b", req_ready, 4'b0001 << w); else pass++;
    m_ptr = (w + 1) % 4;
    exp = ref_op(l_op[idx], l_a[idx], l_b[idx]);
    @(negedge clk); req_valid = 4'hf; #1;
    total++; if (req_ready !== 4'b0) $display("FAIL bp_exec_ready: got %b want 0000", req_ready); else pass++;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      total++; if (res_valid !== 1'b1 || res_data !== exp || res_id !== 2'(idx) || req_ready !== 4'b0)
        $display("FAIL bp_hold%0d: valid %b data %b id %0d ready %b want 1 %b %0d 0000", c, res_valid, res_data, res_id, req_ready, exp, idx); else pass++;
    end
    @(negedge clk); res_ready = 1'b1; #1;
    total++; if (res_valid !== 1'b1) $display("FAIL bp_release_valid: got %b want 1", res_valid); else pass++;
    @(negedge clk); #1;
    w = win_of(4'hf);
    total++; if (res_valid !== 1'b0 || busy !== 1'b0 || req_ready !== (4'b0001 << w))
      $display("FAIL bp_next_idle: valid %b busy %b ready %b want 0 0 %b", res_valid, busy, req_ready, 4'b0001 << w); else pass++;
    req_valid = '0; #1;
    total++; if (req_ready !== 4'b0) $display("FAIL bp_drop: got %b want 0000", req_ready); else pass++;
  endtask

  task automatic test_reset_mid();
    int w;
    logic [3:0] exp;
    rand_lanes();
    @(negedge clk); req_valid = 4'b0010; res_ready = 1'b1; #1;
    w = win_of(req_valid);
    total++; if (req_ready !== (4'b0001 << w)) $display("FAIL mid_grant: got %b want %b", req_ready, 4'b0001 << w); else pass++;
    @(negedge clk); req_valid = '0; rst = 1'b1; #1;
    total++; if (busy !== 1'b1 || req_ready !== 4'b0) $display("FAIL mid_exec: busy %b ready %b want 1 0000", busy, req_ready); else pass++;
    @(negedge clk); rst = 1'b0; m_ptr = 0; #1;
    total++; if (res_valid !== 1'b0 || busy !== 1'b0) $display("FAIL mid_flushed: valid %b busy %b want 0 0", res_valid, busy); else pass++;
    @(negedge clk); req_valid = 4'b1010; #1;
    w = win_of(req_valid);
    total++; if (req_ready !== (4'b0001 << w)) $display("FAIL mid_ptr_zero: got %b want %b", req_ready, 4'b0001 << w); else pass++;
    req_valid = 4'b1000; #1;
    w = win_of(req_valid);
    total++; if (req_ready !== (4'b0001 << w)) $display("FAIL mid_grant3: got %b want %b", req_ready, 4'b0001 << w); else pass++;
    m_ptr = (w + 1) % 4;
    exp = ref_op(l_op[3], l_a[3], l_b[3]);
    @(negedge clk); req_valid = '0; #1;
    total++; if (res_valid !== 1'b0) $display("FAIL mid_exec2_valid: got %b want 0", res_valid); else pass++;
    @(negedge clk); #1;
    total++; if (res_valid !== 1'b1 || res_data !== exp || res_id !== 2'd3)
      $display("FAIL mid_result: valid %b data %b id %0d want 1 %b 3", res_valid, res_data, res_id, exp); else pass++;
    @(negedge clk);
  endtask

  task automatic test_ops();
    logic [1:0] ops [3];
    logic [3:0] as [3], bs [3], exps [3];
    int idx, w;
    ops[0] = 2'd2; as[0] = 4'b1100; bs[0] = 4'b1010;
`ifdef LOGIC_UNIT_ARB_XOR_EN
    exps[0] = 4'b0110;
`else
    exps[0] = 4'b1110;
`endif
    ops[1] = 2'd3; as[1] = 4'b0011; bs[1] = 4'b1111; exps[1] = 4'b1100;
    ops[2] = 2'd0; as[2] = 4'b0110; bs[2] = 4'b1100; exps[2] = 4'b0100;
    res_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      idx = $urandom_range(0, 3);
      rand_lanes();
      l_op[idx] = ops[t]; l_a[idx] = as[t]; l_b[idx] = bs[t];
      req_valid = 4'b0001 << idx; #1;
      w = win_of(req_valid); m_ptr = (w + 1) % 4;
      total++; if (req_ready !== (4'b0001 << idx)) $display("FAIL op%0d_grant: got %b want %b", t, req_ready, 4'b0001 << idx); else pass++;
      @(negedge clk); req_valid = '0;
      @(negedge clk); #1;
      total++; if (res_valid !== 1'b1 || res_data !== exps[t] || res_id !== 2'(idx))
        $display("FAIL op%0d_result: valid %b data %b id %0d want 1 %b %0d", t, res_valid, res_data, res_id, exps[t], idx); else pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    int w, bp;
    logic [3:0] exp;
    for (int t = 0; t < 25; t++) begin
      rand_lanes();
      bp = $urandom_range(0, 3);
      req_valid = 4'($urandom_range(1, 15)); res_ready = 1'($urandom); #1;
      w = win_of(req_valid);
      total++; if (req_ready !== (4'b0001 << w)) $display("FAIL rnd%0d_grant: got %b want %b mask %b", t, req_ready, 4'b0001 << w, req_valid); else pass++;
      exp = ref_op(l_op[w], l_a[w], l_b[w]);
      m_ptr = (w + 1) % 4;
      @(negedge clk); req_valid = 4'($urandom); res_ready = 1'($urandom); rand_lanes(); #1;
      total++; if (req_ready !== 4'b0) $display("FAIL rnd%0d_exec_ready: got %b want 0000", t, req_ready); else pass++;
      @(negedge clk); res_ready = (bp == 0); req_valid = 4'($urandom); rand_lanes(); #1;
      total++; if (res_valid !== 1'b1 || res_data !== exp || res_id !== 2'(w) || req_ready !== 4'b0)
        $display("FAIL rnd%0d_result: valid %b data %b id %0d ready %b want 1 %b %0d 0000", t, res_valid, res_data, res_id, req_ready, exp, w); else pass++;
      for (int k = 0; k < bp; k++) begin
        @(negedge clk); res_ready = (k == bp - 1); #1;
        total++; if (res_valid !== 1'b1 || res_data !== exp || res_id !== 2'(w))
          $display("FAIL rnd%0d_hold%0d: valid %b data %b id %0d want 1 %b %0d", t, k, res_valid, res_data, res_id, exp, w); else pass++;
      end
      @(negedge clk); req_valid = '0; #1;
      total++; if (res_valid !== 1'b0 || busy !== 1'b0) $display("FAIL rnd%0d_idle: valid %b busy %b want 0 0", t, res_valid, busy); else pass++;
      @(negedge clk);
    end
  endtask

  initial begin
    rand_lanes();
    test_reset();
    test_single_or();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_ops();
    test_random();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
